// File: rtl/mul_div_if.sv
// Operand, control and HI/LO result bundle between the CPU datapath and mul_div_unit.
// master = core side, slave = the unit.
interface mul_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] busA;
  logic [WIDTH-1:0] busB;
  logic [1:0]       op;
  logic             start;
  logic             hi_we;
  logic             lo_we;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output busA, busB, op, start, hi_we, lo_we,
    input  busy, done, hi, lo
  );

  modport slave (
    input  busA, busB, op, start, hi_we, lo_we,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers: one multiplier bit or quotient bit per cycle
// on sign-stripped magnitudes, followed by a sign-fix cycle that loads HI/LO.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic      clk,
  input logic      rst_n,
  mul_div_if.slave md
);
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned AccW = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             div_zero_q, div_zero_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic             done_q, done_d;

  logic             sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign sgn_op = md.op[0];
  assign a_neg  = sgn_op & md.busA[WIDTH-1];
  assign b_neg  = sgn_op & md.busB[WIDTH-1];
  assign mag_a  = a_neg ? -md.busA : md.busA;
  assign mag_b  = b_neg ? -md.busB : md.busB;

  // Multiply: acc = {partial product, remaining multiplier bits}, add-then-shift-right.
  logic [WIDTH:0]  mul_sum;
  logic [AccW-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[AccW-1:WIDTH]} + {1'b0, opb_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[AccW-1:1]};

  // Divide: acc = {remainder, dividend bits / quotient bits}; borrow out means restore.
  logic [WIDTH:0]  rem_sh, div_diff;
  logic [AccW-1:0] div_next;
  assign rem_sh   = acc_q[AccW-1:WIDTH-1];
  assign div_diff = rem_sh - {1'b0, opb_q};
  assign div_next = div_diff[WIDTH] ? {acc_q[AccW-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  logic [AccW-1:0]  prod;
  logic [WIDTH-1:0] quo_mag, rem_mag;
  assign prod    = neg_lo_q ? -acc_q : acc_q;
  assign quo_mag = acc_q[WIDTH-1:0];
  assign rem_mag = acc_q[AccW-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    div_zero_d = div_zero_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    opb_d      = opb_q;
    a_raw_d    = a_raw_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    acc_d      = acc_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (md.start) begin
          state_d    = StCalc;
          cnt_d      = '0;
          is_div_d   = md.op[1];
          div_zero_d = md.op[1] && (md.busB == '0);
          neg_lo_d   = a_neg ^ b_neg;
          neg_hi_d   = a_neg;
          a_raw_d    = md.busA;
          if (md.op[1]) begin
            acc_d = {{WIDTH{1'b0}}, mag_a};
            opb_d = mag_b;
          end else begin
            acc_d = {{WIDTH{1'b0}}, mag_b};
            opb_d = mag_a;
          end
        end else begin
          // mthi/mtlo only when no launch competes for the cycle
          if (md.hi_we) hi_d = md.busA;
          if (md.lo_we) lo_d = md.busA;
        end
      end
      StCalc: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod;
        end else if (div_zero_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          lo_d = neg_lo_q ? -quo_mag : quo_mag;
          hi_d = neg_hi_q ? -rem_mag : rem_mag;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      opb_q      <= '0;
      a_raw_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      acc_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      div_zero_q <= div_zero_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      opb_q      <= opb_d;
      a_raw_q    <= a_raw_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      acc_q      <= acc_d;
      done_q     <= done_d;
    end
  end

  assign md.busy = (state_q != StIdle);
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vectors, randomized ops against an arithmetic
// model, back-to-back issue and control corner cases (ignored start/mthi, reset abort).
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mul_div_if #(.WIDTH(32)) md ();
  mul_div_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .md(md));

  int n_tests;
  int n_fail;

  // Reference: {hi, lo} straight from integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, p, q, r;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'd0: return {32'b0, a} * {32'b0, b};
      2'd1: begin p = sa * sb; return p; end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 2'd2) return {a % b, a / b};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Launch one op and wait (bounded) for done; returns at the negedge inside the done cycle.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit now, output int busy_cnt, output bit got_done);
    if (!now) @(negedge clk);
    md.op = o; md.busA = a; md.busB = b; md.start = 1'b1;
    @(negedge clk);
    md.start = 1'b0;
    busy_cnt = 0;
    got_done = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      if (md.done) got_done = 1'b1;
      else begin
        if (md.busy) busy_cnt++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    n_tests++; if (md.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", md.busy); end
    n_tests++; if (md.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", md.done); end
    n_tests++; if (md.hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", md.hi); end
    n_tests++; if (md.lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", md.lo); end
  endtask

  task automatic test_directed();
    logic [1:0]  v_op[5] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd3};
    logic [31:0] v_a[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000};
    logic [31:0] v_b[5]  = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] v_hi[5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd0};
    logic [31:0] v_lo[5] = '{32'h1, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    int bc;
    bit gd;
    for (int i = 0; i < 5; i++) begin
      do_op(v_op[i], v_a[i], v_b[i], 1'b0, bc, gd);
      n_tests++; if (!gd) begin n_fail++; $display("FAIL dir%0d_done: got none expected pulse", i); end
      n_tests++; if (bc != 33) begin n_fail++; $display("FAIL dir%0d_busy_cycles: got %0d expected 33", i, bc); end
      n_tests++; if (md.busy !== 1'b0) begin n_fail++; $display("FAIL dir%0d_busy_at_done: got %b expected 0", i, md.busy); end
      n_tests++; if (md.hi !== v_hi[i]) begin n_fail++; $display("FAIL dir%0d_hi: got %h expected %h", i, md.hi, v_hi[i]); end
      n_tests++; if (md.lo !== v_lo[i]) begin n_fail++; $display("FAIL dir%0d_lo: got %h expected %h", i, md.lo, v_lo[i]); end
      @(negedge clk);
      n_tests++; if (md.done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_width: got %b expected 0", i, md.done); end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] exp;
    int bc;
    bit gd;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 5);
        2: b = -($urandom_range(1, 5));
        default: b = $urandom;
      endcase
      exp = model(o, a, b);
      do_op(o, a, b, 1'b0, bc, gd);
      n_tests++;
      if (!gd || md.hi !== exp[63:32] || md.lo !== exp[31:0]) begin
        n_fail++;
        $display("FAIL rand%0d op=%0d a=%h b=%h: got done=%b hi=%h lo=%h expected hi=%h lo=%h",
                 i, o, a, b, gd, md.hi, md.lo, exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bc;
    bit gd;
    do_op(2'd0, 32'd6, 32'd7, 1'b0, bc, gd);
    n_tests++; if (md.lo !== 32'd42) begin n_fail++; $display("FAIL b2b_first_lo: got %h expected 2a", md.lo); end
    do_op(2'd2, 32'd100, 32'd7, 1'b1, bc, gd);
    n_tests++; if (!gd || bc != 33) begin n_fail++; $display("FAIL b2b_accept: got done=%b busy=%0d expected 1/33", gd, bc); end
    n_tests++; if (md.hi !== 32'd2 || md.lo !== 32'd14) begin n_fail++; $display("FAIL b2b_result: got hi=%h lo=%h expected 2/e", md.hi, md.lo); end
  endtask

  task automatic test_control();
    bit gd;
    int dcount;
    // MULTU 3*4 with a stray start and mthi while busy
    @(negedge clk);
    md.op = 2'd0; md.busA = 32'd3; md.busB = 32'd4; md.start = 1'b1;
    @(negedge clk);
    md.start = 1'b0;
    repeat (5) @(negedge clk);
    md.busA = 32'd9; md.start = 1'b1;
    @(negedge clk);
    md.start = 1'b0;
    n_tests++; if (md.hi !== 32'd2 || md.lo !== 32'd14) begin n_fail++; $display("FAIL hold_during_calc: got hi=%h lo=%h expected 2/e", md.hi, md.lo); end
    md.busA = 32'hABCD; md.hi_we = 1'b1;
    @(negedge clk);
    md.hi_we = 1'b0;
    n_tests++; if (md.hi !== 32'd2) begin n_fail++; $display("FAIL mthi_busy: got %h expected 2", md.hi); end
    gd = 1'b0;
    for (int i = 0; i < 40 && !gd; i++) if (md.done) gd = 1'b1; else @(negedge clk);
    n_tests++; if (!gd || md.lo !== 32'd12 || md.hi !== 32'd0) begin n_fail++; $display("FAIL restart_ignored: got done=%b hi=%h lo=%h expected 1/0/c", gd, md.hi, md.lo); end
    @(negedge clk);
    n_tests++; if (md.busy !== 1'b0) begin n_fail++; $display("FAIL no_queue: got busy=%b expected 0", md.busy); end
    // mthi in idle
    md.busA = 32'h1234; md.hi_we = 1'b1;
    @(negedge clk);
    md.hi_we = 1'b0;
    n_tests++; if (md.hi !== 32'h1234 || md.lo !== 32'd12 || md.done !== 1'b0) begin n_fail++; $display("FAIL mthi_idle: got hi=%h lo=%h done=%b expected 1234/c/0", md.hi, md.lo, md.done); end
    md.busA = 32'h55; md.hi_we = 1'b1; md.lo_we = 1'b1;
    @(negedge clk);
    md.hi_we = 1'b0; md.lo_we = 1'b0;
    n_tests++; if (md.hi !== 32'h55 || md.lo !== 32'h55) begin n_fail++; $display("FAIL mthi_mtlo: got hi=%h lo=%h expected 55/55", md.hi, md.lo); end
    // start beats a same-cycle mthi
    md.op = 2'd0; md.busA = 32'h77; md.busB = 32'd1; md.start = 1'b1; md.hi_we = 1'b1;
    @(negedge clk);
    md.start = 1'b0; md.hi_we = 1'b0;
    n_tests++; if (md.busy !== 1'b1 || md.hi !== 32'h55) begin n_fail++; $display("FAIL start_wins: got busy=%b hi=%h expected 1/55", md.busy, md.hi); end
    gd = 1'b0;
    for (int i = 0; i < 40 && !gd; i++) if (md.done) gd = 1'b1; else @(negedge clk);
    n_tests++; if (!gd || md.hi !== 32'd0 || md.lo !== 32'h77) begin n_fail++; $display("FAIL start_wins_result: got done=%b hi=%h lo=%h expected 1/0/77", gd, md.hi, md.lo); end
    // reset mid-operation
    @(negedge clk);
    md.busA = 32'hBEEF; md.hi_we = 1'b1;
    @(negedge clk);
    md.hi_we = 1'b0;
    md.op = 2'd0; md.busA = 32'hFF; md.busB = 32'hFF; md.start = 1'b1;
    @(negedge clk);
    md.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++; if (md.busy !== 1'b0 || md.hi !== 32'd0 || md.lo !== 32'd0) begin n_fail++; $display("FAIL reset_abort: got busy=%b hi=%h lo=%h expected 0/0/0", md.busy, md.hi, md.lo); end
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (md.done || md.busy) dcount++;
    end
    n_tests++; if (dcount != 0) begin n_fail++; $display("FAIL reset_no_done: got %0d done/busy cycles expected 0", dcount); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    md.busA = '0; md.busB = '0; md.op = '0;
    md.start = 1'b0; md.hi_we = 1'b0; md.lo_we = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_control();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
